// File: rtl/rv_controller.sv
// Word-by-word block controller: accepts words from upstream, strobes the datapath
// input/output registers, hands results downstream and counts delivered results.
module rv_controller #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             input_ld,
  output logic             output_ld,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] words_done
);

  // state    | meaning
  // IDLE     | no block active, waiting for start
  // WAIT_IN  | ready for the next upstream word
  // EVAL     | datapath evaluating, output register loads this cycle
  // WAIT_OUT | result presented, waiting for downstream
  // DONE     | one-cycle completion pulse
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_IN  = 3'd1,
    EVAL     = 3'd2,
    WAIT_OUT = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_words_done;
  logic [CNT_W-1:0] w_wd_inc;
  logic             w_accept_start;
  logic             w_out_hs;

  assign w_wd_inc       = r_words_done + CNT_W'(1);
  assign w_accept_start = (r_state == IDLE) && start;
  assign w_out_hs       = (r_state == WAIT_OUT) && out_ready && !abort;
  assign words_done     = r_words_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_words_done <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept_start) begin
        r_count      <= word_count;
        r_words_done <= '0;
      end else if (w_out_hs) begin
        r_words_done <= w_wd_inc;
      end
    end
  end

  // in_ready drops under abort so a cancelled cycle can never complete an input handshake
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    input_ld    = 1'b0;
    output_ld   = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = (word_count == '0) ? DONE : WAIT_IN;
        end
      end
      WAIT_IN: begin
        in_ready = !abort;
        input_ld = in_valid && !abort;
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (in_valid) begin
          w_state_nxt = EVAL;
        end
      end
      EVAL: begin
        output_ld   = 1'b1;
        w_state_nxt = abort ? IDLE : WAIT_OUT;
      end
      WAIT_OUT: begin
        out_valid = 1'b1;
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (out_ready) begin
          w_state_nxt = (w_wd_inc == r_count) ? DONE : WAIT_IN;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rv_controller.sv
// Self-checking bench for rv_controller: vector table, directed block runs and a
// randomized run against a handshake/latency-level reference model.
module tb_rv_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] word_count;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic       input_ld;
  logic       output_ld;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic [4:0] words_done;

  int n_cmp = 0;
  int n_err = 0;

  rv_controller #(.CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .input_ld(input_ld), .output_ld(output_ld),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .words_done(words_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {in_ready, input_ld, output_ld, out_valid, busy, done, words_done};
  endfunction

  typedef struct {
    logic       st;
    logic [4:0] wc;
    logic       ab;
    logic       iv;
    logic       ordy;
    logic [5:0] exp_ctl;
    logic [4:0] exp_wd;
  } vec_t;

  vec_t vec[17];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; word_count = '0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    #1 chk("reset_outputs", {21'd0, outs()}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_full(input logic [4:0] wc, input logic [4:0] alt, input int stall,
                          output int n_in, output int n_out, output int n_busy,
                          output int n_done, output int n_ovl, output int first_ov,
                          output logic [4:0] wd_end);
    bit fin, seen_done, hs_seen;
    int stall_used;
    n_in = 0; n_out = 0; n_busy = 0; n_done = 0; n_ovl = 0; first_ov = 0; wd_end = '1;
    fin = 0; seen_done = 0; hs_seen = 0; stall_used = 0;
    @(negedge clk);
    start = 1'b1; word_count = wc; in_valid = 1'b1; out_ready = 1'b1; abort = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      #1;
      if (input_ld) n_in++;
      if (output_ld) n_out++;
      if (input_ld && output_ld) n_ovl++;
      if (done) n_done++;
      else if (busy) n_busy++;
      if (seen_done && !busy) begin
        fin = 1;
        wd_end = words_done;
      end
      if (done) seen_done = 1;
      out_ready = !(out_valid && stall_used < stall);
      if (!out_ready) stall_used++;
      if (out_valid && !hs_seen) first_ov++;
      if (out_valid && out_ready) hs_seen = 1;
      if (!fin) begin
        @(negedge clk);
        start = (c == 1) && (alt != wc);
        word_count = (c == 1) ? alt : wc;
      end
    end
    if (!fin) begin
      n_err++;
      $display("FAIL run_full_timeout: block of %0d words never completed", wc);
    end
    start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
  endtask

  // reference model state (transaction/latency level)
  bit          m_active, m_inflight, m_done_pend;
  int          m_n, m_del, m_tin, m_cyc;

  initial begin
    int n_in, n_out, n_busy, n_done, n_ovl, first_ov;
    logic [4:0] wd_end;
    logic [10:0] exp_o;
    bit e_ir, e_ild, e_old, e_ov, new_done;

    rst = 1'b1; start = 1'b0; word_count = '0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    do_reset();

    vec[0]  = '{1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000000, 5'd0};
    vec[1]  = '{1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 6'b000000, 5'd0};
    vec[2]  = '{1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 6'b100010, 5'd0};
    vec[3]  = '{1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 6'b110010, 5'd0};
    vec[4]  = '{1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 6'b001010, 5'd0};
    vec[5]  = '{1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000110, 5'd0};
    vec[6]  = '{1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'b000110, 5'd0};
    vec[7]  = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 6'b000010, 5'd1};
    vec[8]  = '{1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000000, 5'd1};
    vec[9]  = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 6'b000011, 5'd0};
    vec[10] = '{1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000000, 5'd0};
    vec[11] = '{1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 6'b000000, 5'd0};
    vec[12] = '{1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 6'b110010, 5'd0};
    vec[13] = '{1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b001010, 5'd0};
    vec[14] = '{1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'b000110, 5'd0};
    vec[15] = '{1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000011, 5'd1};
    vec[16] = '{1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000000, 5'd1};

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      start = vec[i].st; word_count = vec[i].wc; abort = vec[i].ab;
      in_valid = vec[i].iv; out_ready = vec[i].ordy;
      #1 chk($sformatf("vec%0d", i), {21'd0, outs()}, {21'd0, vec[i].exp_ctl, vec[i].exp_wd});
    end
    abort = 1'b0;

    run_full(5'd3, 5'd3, 0, n_in, n_out, n_busy, n_done, n_ovl, first_ov, wd_end);
    chk("wc3_input_ld", n_in, 3);
    chk("wc3_output_ld", n_out, 3);
    chk("wc3_busy_cycles", n_busy, 9);
    chk("wc3_done", n_done, 1);
    chk("wc3_overlap", n_ovl, 0);
    chk("wc3_words_done", wd_end, 3);

    run_full(5'd2, 5'd2, 4, n_in, n_out, n_busy, n_done, n_ovl, first_ov, wd_end);
    chk("stall_first_ov", first_ov, 5);
    chk("stall_input_ld", n_in, 2);
    chk("stall_words_done", wd_end, 2);

    run_full(5'd0, 5'd0, 0, n_in, n_out, n_busy, n_done, n_ovl, first_ov, wd_end);
    chk("wc0_loads", n_in + n_out, 0);
    chk("wc0_done", n_done, 1);
    chk("wc0_words_done", wd_end, 0);

    run_full(5'd2, 5'd5, 0, n_in, n_out, n_busy, n_done, n_ovl, first_ov, wd_end);
    chk("restart_ignored_in", n_in, 2);
    chk("restart_ignored_busy", n_busy, 6);
    chk("restart_ignored_wd", wd_end, 2);

    run_full(5'd31, 5'd31, 0, n_in, n_out, n_busy, n_done, n_ovl, first_ov, wd_end);
    chk("max_busy", n_busy, 93);
    chk("max_done", n_done, 1);
    chk("max_words_done", wd_end, 31);

    // abort while the second result is being handed off
    @(negedge clk);
    start = 1'b1; word_count = 5'd4; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    abort = 1'b1;
    #1 chk("abort_ov", out_valid, 1'b1);
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1 chk("abort_state", {busy, done, words_done}, {2'b00, 5'd1});
    n_done = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 if (done) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    run_full(5'd2, 5'd2, 0, n_in, n_out, n_busy, n_done, n_ovl, first_ov, wd_end);
    chk("abort_restart_wd", wd_end, 2);
    chk("abort_restart_done", n_done, 1);

    // asynchronous reset in EVAL
    @(negedge clk);
    start = 1'b1; word_count = 5'd2; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 chk("eval_output_ld", output_ld, 1'b1);
    #1 rst = 1'b0;
    #1 chk("async_reset_outs", {21'd0, outs()}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_full(5'd1, 5'd1, 0, n_in, n_out, n_busy, n_done, n_ovl, first_ov, wd_end);
    chk("post_reset_block", {n_in[7:0], n_done[7:0], 3'd0, wd_end}, {8'd1, 8'd1, 3'd0, 5'd1});

    // randomized run against the reference model
    do_reset();
    m_active = 0; m_inflight = 0; m_done_pend = 0; m_n = 0; m_del = 0; m_tin = -10; m_cyc = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      start      = ($urandom_range(0, 3) == 0);
      word_count = 5'($urandom_range(0, 4));
      abort      = ($urandom_range(0, 19) == 0);
      in_valid   = 1'($urandom_range(0, 1));
      out_ready  = 1'($urandom_range(0, 1));
      e_ir  = m_active && !m_inflight && !abort;
      e_ild = e_ir && in_valid;
      e_old = m_active && m_inflight && (m_cyc == m_tin + 1);
      e_ov  = m_active && m_inflight && (m_cyc >= m_tin + 2);
      exp_o = {e_ir, e_ild, e_old, e_ov, m_active || m_done_pend, m_done_pend, 5'(m_del)};
      #1 chk("random", {21'd0, outs()}, {21'd0, exp_o});
      new_done = 0;
      if (m_done_pend) begin
        new_done = 0;
      end else if (!m_active) begin
        if (start) begin
          m_del = 0;
          if (word_count == 0) new_done = 1;
          else begin
            m_active = 1; m_n = word_count; m_inflight = 0;
          end
        end
      end else if (abort) begin
        m_active = 0; m_inflight = 0;
      end else if (e_ild) begin
        m_inflight = 1; m_tin = m_cyc;
      end else if (e_ov && out_ready) begin
        m_del++;
        m_inflight = 0;
        if (m_del == m_n) begin
          m_active = 0; new_done = 1;
        end
      end
      m_done_pend = new_done;
      m_cyc++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
